// File: rtl/pipe_reg_fd_skid.sv
// pipe_reg_fd_skid
// ----------------
// Fetch-to-decode pipeline register with a two-entry skid buffer and a
// valid/ready handshake on both sides.
//
// Handshake rule (both sides):
//   A beat transfers on a rising edge only when valid and ready are both 1.
//   Once valid is raised, the producer holds valid and the payload steady
//   until the beat transfers. The one exception is a flush or reset, which
//   may drop valid.
//   readyF_o is a flop, so nothing in this block feeds readyD_i
//   combinationally back to fetch.
//
// Ports:
//   clk_i        clock; all state updates happen on the rising edge
//   rst_i        synchronous reset, active-high
//   validF_i     fetch presents a valid beat
//   readyF_o     stage can accept a beat; registered, equals (occ != 2)
//   rd_i         instruction word from instruction memory
//   pcF_i        fetch PC
//   pc_plus4F_i  fetch PC+4
//   flush_i      discard all held beats and the beat offered this cycle
//   readyD_i     decode accepts the current beat
//   validD_o     instrD_o / pcD_o / pc_plus4D_o hold a valid beat
//   instrD_o     decode instruction; NOP_INSTR while the stage is empty
//   pcD_o        decode PC; 0 while the stage is empty
//   pc_plus4D_o  decode PC+4; 0 while the stage is empty
//   occ_o        occupancy: 0, 1 or 2
module pipe_reg_fd_skid #(
  parameter int unsigned            ADDRESS_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0]  NOP_INSTR     = 32'h00000013
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     validF_i,
  output logic                     readyF_o,
  input  logic [DATA_WIDTH-1:0]    rd_i,
  input  logic [ADDRESS_WIDTH-1:0] pcF_i,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4F_i,
  input  logic                     flush_i,
  input  logic                     readyD_i,
  output logic                     validD_o,
  output logic [DATA_WIDTH-1:0]    instrD_o,
  output logic [ADDRESS_WIDTH-1:0] pcD_o,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4D_o,
  output logic [1:0]               occ_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                   state_q;

  // Main slot: drives the decode outputs directly.
  logic                     main_valid_q;
  logic [DATA_WIDTH-1:0]    main_instr_q;
  logic [ADDRESS_WIDTH-1:0] main_pc_q;
  logic [ADDRESS_WIDTH-1:0] main_pc4_q;

  // Skid slot: catches the beat fetch sent while decode was stalled.
  logic                     skid_valid_q;
  logic [DATA_WIDTH-1:0]    skid_instr_q;
  logic [ADDRESS_WIDTH-1:0] skid_pc_q;
  logic [ADDRESS_WIDTH-1:0] skid_pc4_q;

  logic                     ready_q;
  logic [1:0]               occ_q;

  logic acc_f;
  logic acc_d;

  assign acc_f = validF_i & ready_q;
  assign acc_d = main_valid_q & readyD_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      // Reset and flush end in the same state. Any beat offered by fetch or
      // taken by decode this cycle is simply forgotten here.
      state_q      <= EMPTY;
      main_valid_q <= 1'b0;
      main_instr_q <= NOP_INSTR;
      main_pc_q    <= '0;
      main_pc4_q   <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      occ_q        <= 2'd0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc_f) begin
            state_q      <= ONE;
            main_valid_q <= 1'b1;
            main_instr_q <= rd_i;
            main_pc_q    <= pcF_i;
            main_pc4_q   <= pc_plus4F_i;
            occ_q        <= 2'd1;
          end
        end
        ONE: begin
          if (acc_f && acc_d) begin
            // Pass-through: the new beat replaces the consumed one.
            main_instr_q <= rd_i;
            main_pc_q    <= pcF_i;
            main_pc4_q   <= pc_plus4F_i;
          end else if (acc_f) begin
            // Decode stalled. Park the new beat and hold the main slot.
            state_q      <= FULL;
            skid_valid_q <= 1'b1;
            skid_instr_q <= rd_i;
            skid_pc_q    <= pcF_i;
            skid_pc4_q   <= pc_plus4F_i;
            ready_q      <= 1'b0;
            occ_q        <= 2'd2;
          end else if (acc_d) begin
            state_q      <= EMPTY;
            main_valid_q <= 1'b0;
            main_instr_q <= NOP_INSTR;
            main_pc_q    <= '0;
            main_pc4_q   <= '0;
            occ_q        <= 2'd0;
          end
        end
        FULL: begin
          // ready_q is 0 here, so acc_f cannot occur.
          if (acc_d && skid_valid_q) begin
            state_q      <= ONE;
            main_instr_q <= skid_instr_q;
            main_pc_q    <= skid_pc_q;
            main_pc4_q   <= skid_pc4_q;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            occ_q        <= 2'd1;
          end
        end
        default: begin
          state_q      <= EMPTY;
          main_valid_q <= 1'b0;
          main_instr_q <= NOP_INSTR;
          main_pc_q    <= '0;
          main_pc4_q   <= '0;
          skid_valid_q <= 1'b0;
          ready_q      <= 1'b1;
          occ_q        <= 2'd0;
        end
      endcase
    end
  end

  assign readyF_o    = ready_q;
  assign validD_o    = main_valid_q;
  assign instrD_o    = main_instr_q;
  assign pcD_o       = main_pc_q;
  assign pc_plus4D_o = main_pc4_q;
  assign occ_o       = occ_q;

endmodule

// File: tb/tb_pipe_reg_fd_skid.sv
// Testbench for pipe_reg_fd_skid. The reference model is a bounded FIFO,
// exp_q, that holds up to two beats. Its size is the occupancy, and its head
// is what decode must see.
module tb_pipe_reg_fd_skid;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] NOP = 32'h00000013;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_i;
  logic          validF_i;
  logic          readyF_o;
  logic [DW-1:0] rd_i;
  logic [AW-1:0] pcF_i;
  logic [AW-1:0] pc_plus4F_i;
  logic          flush_i;
  logic          readyD_i;
  logic          validD_o;
  logic [DW-1:0] instrD_o;
  logic [AW-1:0] pcD_o;
  logic [AW-1:0] pc_plus4D_o;
  logic [1:0]    occ_o;

  pipe_reg_fd_skid #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .NOP_INSTR    (NOP)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .validF_i    (validF_i),
    .readyF_o    (readyF_o),
    .rd_i        (rd_i),
    .pcF_i       (pcF_i),
    .pc_plus4F_i (pc_plus4F_i),
    .flush_i     (flush_i),
    .readyD_i    (readyD_i),
    .validD_o    (validD_o),
    .instrD_o    (instrD_o),
    .pcD_o       (pcD_o),
    .pc_plus4D_o (pc_plus4D_o),
    .occ_o       (occ_o)
  );

  // ---------------- scoreboard ----------------
  // Each entry is {instr, pc, pc_plus4}.
  logic [DW+2*AW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_consumed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [DW+2*AW-1:0] head;
    check("occ", 64'(occ_o), 64'(exp_q.size()));
    check("readyF", 64'(readyF_o), 64'(exp_q.size() != 2));
    check("validD", 64'(validD_o), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("instrD", 64'(instrD_o), 64'(head[DW+2*AW-1:2*AW]));
      check("pcD", 64'(pcD_o), 64'(head[2*AW-1:AW]));
      check("pc_plus4D", 64'(pc_plus4D_o), 64'(head[AW-1:0]));
    end else begin
      check("instrD_nop", 64'(instrD_o), 64'(NOP));
      check("pcD_zero", 64'(pcD_o), 64'd0);
      check("pc_plus4D_zero", 64'(pc_plus4D_o), 64'd0);
    end
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs, advance the model at the edge, then check the
  // outputs 1 time unit after the edge.
  task automatic cycle(input logic v, input logic [DW-1:0] instr, input logic [AW-1:0] pc,
                       input logic rdy, input logic fl, input logic rs);
    logic acc_f;
    logic acc_d;
    validF_i    = v;
    rd_i        = instr;
    pcF_i       = pc;
    pc_plus4F_i = pc + 32'd4;
    readyD_i    = rdy;
    flush_i     = fl;
    rst_i       = rs;
    @(posedge clk_i);
    acc_f = v && (exp_q.size() != 2);
    acc_d = rdy && (exp_q.size() != 0);
    if (rs || fl) begin
      exp_q.delete();
    end else begin
      if (acc_d) begin
        void'(exp_q.pop_front());
        n_consumed++;
      end
      if (acc_f) exp_q.push_back({instr, pc, pc + 32'd4});
    end
    #1;
    check_outputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    validF_i = 1'b0; rd_i = '0; pcF_i = '0; pc_plus4F_i = '0;
    flush_i = 1'b0; readyD_i = 1'b0; rst_i = 1'b1;

    // Hold reset for two cycles with fetch offering a beat.
    cycle(1'b1, 32'hA, 32'h0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'hA, 32'h0, 1'b1, 1'b0, 1'b1);

    // Streaming with decode always ready.
    cycle(1'b1, 32'hA, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 32'h4, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'hC, 32'h8, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Stall and skid, then release.
    cycle(1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h11, 32'h4, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h12, 32'h8, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h12, 32'h8, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h12, 32'h8, 1'b1, 1'b0, 1'b0);

    // Refill to FULL, then flush while fetch offers pc 0x8.
    cycle(1'b1, 32'h12, 32'h8, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h99, 32'h8, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Reset and flush together while one beat is held; the next beat is
    // accepted normally.
    cycle(1'b1, 32'h20, 32'h40, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h77, 32'h80, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 32'h21, 32'h100, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Random traffic, with about 2% flush.
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) < 2), 1'b0);
    end

    // A run with no consumed beats means the bench never exercised decode.
    check("beats_consumed", 64'(n_consumed > 1000), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
